mult_result_buffer: RTL and testbench

MULT_RESULT_BUFFER -- requirements
Module: mult_result_buffer

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_res_fifo.sv | 62 ++++++
 rtl/mult_result_buffer.sv | 94 +++++++++
 tb/tb_mult_result_buffer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared widths and types for the multiplier result buffer slice.
package mult_pkg;

    localparam int unsigned N       = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned LEVEL_W = $clog2(DEPTH + 1);

    typedef logic signed [2*N-1:0] prod_t;

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mult_res_fifo.sv
// Synchronous result FIFO; a pop in the same cycle frees the slot for a push when full.
module mult_res_fifo
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * mult_pkg::N,
    parameter int unsigned DEPTH = mult_pkg::DEPTH,
    parameter int unsigned LW    = mult_pkg::LEVEL_W
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is forced to zero while empty so the output is defined without resetting storage.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLOCK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mult_result_buffer.sv
// Credit-based operand issue to an external multiplier with an in-order result FIFO.
module mult_result_buffer
    import mult_pkg::*;
#(
    parameter int unsigned N     = mult_pkg::N,
    parameter int unsigned DEPTH = mult_pkg::DEPTH,
    parameter int unsigned LW    = level_width(DEPTH)
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic signed [N-1:0]   A_IN,
    input  logic signed [N-1:0]   B_IN,
    output logic                  START,
    output logic signed [N-1:0]   A,
    output logic signed [N-1:0]   B,
    input  logic signed [2*N-1:0] S,
    input  logic                  END_MULT,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic signed [2*N-1:0] OUT_DATA,
    output logic [LW-1:0]         LEVEL,
    output logic                  OVERFLOW
);

    logic [LW-1:0]    inflight;
    logic [LW:0]      occupancy;
    logic             issue;
    logic             pop;
    logic             end_counted;
    logic             fifo_full;
    logic             fifo_empty;
    logic [2*N-1:0]   fifo_dout;

    // Every slot is reserved at issue time, so a returning product always has room.
    assign occupancy   = {1'b0, LEVEL} + {1'b0, inflight};
    assign IN_READY    = (occupancy < (LW+1)'(DEPTH));
    assign issue       = IN_VALID && IN_READY;
    assign OUT_VALID   = !fifo_empty;
    assign pop         = OUT_VALID && OUT_READY;
    assign end_counted = END_MULT && (inflight != '0);
    assign OUT_DATA    = fifo_dout;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            START <= 1'b0;
            A     <= '0;
            B     <= '0;
        end else begin
            START <= issue;
            if (issue) begin
                A <= A_IN;
                B <= B_IN;
            end
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            inflight <= '0;
        end else if (issue && !end_counted) begin
            inflight <= inflight + 1'b1;
        end else if (!issue && end_counted) begin
            inflight <= inflight - 1'b1;
        end
    end

    // Sticky: a dropped product, or a return with nothing outstanding.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            OVERFLOW <= 1'b0;
        end else if (END_MULT && ((fifo_full && !pop) || (inflight == '0))) begin
            OVERFLOW <= 1'b1;
        end
    end

    mult_res_fifo #(
        .WIDTH (2 * N),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .push  (END_MULT),
        .pop   (pop),
        .din   (S),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (LEVEL)
    );

endmodule

// File: tb/tb_mult_result_buffer.sv
// Scoreboard bench for mult_result_buffer with a 9-cycle multiplier model.
module tb_mult_result_buffer;
    import mult_pkg::*;

    localparam int unsigned TD  = 4;
    localparam int unsigned LAT = 9;

    logic               CLOCK = 1'b0;
    logic               RESET;
    logic               IN_VALID;
    logic               IN_READY;
    logic signed [7:0]  A_IN;
    logic signed [7:0]  B_IN;
    logic               START;
    logic signed [7:0]  A;
    logic signed [7:0]  B;
    logic signed [15:0] S;
    logic               END_MULT;
    logic               OUT_VALID;
    logic               OUT_READY;
    logic signed [15:0] OUT_DATA;
    logic [2:0]         LEVEL;
    logic               OVERFLOW;

    mult_result_buffer #(.N(8), .DEPTH(4)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A_IN      (A_IN),
        .B_IN      (B_IN),
        .START     (START),
        .A         (A),
        .B         (B),
        .S         (S),
        .END_MULT  (END_MULT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .LEVEL     (LEVEL),
        .OVERFLOW  (OVERFLOW)
    );

    always #5 CLOCK = ~CLOCK;

    int total = 0;
    int bad   = 0;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic prod_t mul(input logic signed [7:0] a, input logic signed [7:0] b);
        return prod_t'(int'(a) * int'(b));
    endfunction

    // Multiplier model plus an injection port for forcing END_MULT.
    logic  pv [LAT];
    prod_t pp [LAT];
    bit    inj_req = 1'b0;
    prod_t inj_val = '0;
    bit    end_inj = 1'b0;

    initial begin
        END_MULT = 1'b0;
        S        = '0;
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0;
            pp[i] = '0;
        end
        forever begin
            @(posedge CLOCK);
            #1;
            if (RESET) begin
                for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
                END_MULT = 1'b0;
                end_inj  = 1'b0;
                inj_req  = 1'b0;
            end else begin
                END_MULT = pv[LAT-1] | inj_req;
                end_inj  = inj_req;
                S        = inj_req ? inj_val : pp[LAT-1];
                inj_req  = 1'b0;
                for (int i = LAT - 1; i > 0; i--) begin
                    pv[i] = pv[i-1];
                    pp[i] = pp[i-1];
                end
                pv[0] = START;
                pp[0] = mul(A, B);
            end
        end
    end

    // Reference model: products queued at issue, FIFO contents, sticky overflow.
    prod_t       flight_q [$];
    prod_t       fifo_q   [$];
    logic [15:0] got_q    [$];
    bit          m_ovf       = 1'b0;
    int          hs_count    = 0;
    int          start_count = 0;
    int          valid_count = 0;

    initial begin
        forever begin
            @(negedge CLOCK);
            if (RESET) begin
                flight_q.delete();
                fifo_q.delete();
                m_ovf = 1'b0;
                check("rst_level", LEVEL, 0);
                check("rst_out_valid", OUT_VALID, 0);
                check("rst_out_data", OUT_DATA, 0);
                check("rst_in_ready", IN_READY, 1);
                check("rst_start", START, 0);
                check("rst_a", A, 0);
                check("rst_b", B, 0);
                check("rst_overflow", OVERFLOW, 0);
            end else begin
                prod_t v;
                bit    proto;
                check("level", LEVEL, fifo_q.size());
                check("out_valid", OUT_VALID, fifo_q.size() != 0);
                check("overflow", OVERFLOW, m_ovf);
                check("in_ready", IN_READY, (fifo_q.size() + flight_q.size()) < TD);
                if (START) start_count++;
                if (OUT_VALID) valid_count++;
                if (OUT_VALID && fifo_q.size() != 0) check("head", OUT_DATA, fifo_q[0]);
                if (OUT_VALID && OUT_READY) begin
                    if (fifo_q.size() == 0) begin
                        check("pop_unexpected", OUT_VALID, 0);
                    end else begin
                        got_q.push_back(OUT_DATA);
                        void'(fifo_q.pop_front());
                    end
                end
                if (END_MULT) begin
                    proto = (flight_q.size() == 0);
                    if (end_inj || proto) v = S;
                    else v = flight_q.pop_front();
                    if (proto) m_ovf = 1'b1;
                    if (fifo_q.size() < TD) fifo_q.push_back(v);
                    else m_ovf = 1'b1;
                end
                if (IN_VALID && IN_READY) begin
                    flight_q.push_back(mul(A_IN, B_IN));
                    hs_count++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK);
        #2;
    endtask

    // Present up to cnt random requests, holding IN_VALID until each handshakes.
    task automatic issue_n(input int cnt, input int budget);
        int h0;
        h0 = hs_count;
        for (int c = 0; c < budget; c++) begin
            if (hs_count - h0 < cnt) begin
                if (!IN_VALID || IN_READY) begin
                    A_IN = 8'($urandom);
                    B_IN = 8'($urandom);
                end
                IN_VALID = 1'b1;
            end else begin
                IN_VALID = 1'b0;
            end
            cyc(1);
        end
        IN_VALID = 1'b0;
    endtask

    logic signed [7:0] t3a [3];
    logic signed [7:0] t3b [3];
    logic signed [7:0] t6a [6];
    logic signed [7:0] t6b [6];
    logic [15:0]       e;
    int                sc, vc, h0;

    initial begin
        t3a = '{-8'sd128, -8'sd128, 8'sd0};
        t3b = '{-8'sd128, 8'sd127, 8'sd55};
        t6a = '{8'sd1, -8'sd2, 8'sd3, 8'sd100, -8'sd77, 8'sd12};
        t6b = '{8'sd5, 8'sd9, -8'sd11, -8'sd100, 8'sd33, 8'sd12};

        RESET = 1'b0; IN_VALID = 1'b0; A_IN = '0; B_IN = '0; OUT_READY = 1'b0;
        #1 RESET = 1'b1;
        #1;
        check("por_level", LEVEL, 0);
        check("por_in_ready", IN_READY, 1);
        check("por_out_valid", OUT_VALID, 0);
        check("por_overflow", OVERFLOW, 0);
        cyc(3);
        RESET = 1'b0;
        cyc(2);

        // Single operation 7 x -3.
        OUT_READY = 1'b1; sc = start_count; vc = valid_count; got_q.delete();
        A_IN = 8'sd7; B_IN = -8'sd3; IN_VALID = 1'b1;
        cyc(1);
        IN_VALID = 1'b0;
        cyc(20);
        check("s1_start_pulses", start_count - sc, 1);
        check("s1_valid_cycles", valid_count - vc, 1);
        check("s1_results", got_q.size(), 1);
        if (got_q.size() >= 1) check("s1_data", got_q[0], 16'hFFEB);
        check("s1_level", LEVEL, 0);

        // Corner values, back to back.
        sc = start_count; got_q.delete();
        for (int i = 0; i < 3; i++) begin
            A_IN = t3a[i]; B_IN = t3b[i]; IN_VALID = 1'b1;
            cyc(1);
        end
        IN_VALID = 1'b0;
        cyc(25);
        check("s2_start_pulses", start_count - sc, 3);
        check("s2_results", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("s2_r0", got_q[0], 16'h4000);
            check("s2_r1", got_q[1], 16'hC080);
            check("s2_r2", got_q[2], 16'h0000);
        end

        // Credit stall with six requests and the sink blocked.
        OUT_READY = 1'b0; h0 = hs_count; got_q.delete();
        for (int c = 0; c < 25; c++) begin
            int k;
            k = hs_count - h0;
            A_IN = t6a[k < 6 ? k : 5]; B_IN = t6b[k < 6 ? k : 5]; IN_VALID = (k < 6);
            cyc(1);
        end
        check("s3_handshakes_stalled", hs_count - h0, 4);
        check("s3_in_ready_low", IN_READY, 0);
        check("s3_level_full", LEVEL, 4);
        check("s3_overflow", OVERFLOW, 0);
        OUT_READY = 1'b1;
        for (int c = 0; c < 40; c++) begin
            int k;
            k = hs_count - h0;
            A_IN = t6a[k < 6 ? k : 5]; B_IN = t6b[k < 6 ? k : 5]; IN_VALID = (k < 6);
            cyc(1);
        end
        IN_VALID = 1'b0;
        cyc(5);
        check("s3_handshakes_total", hs_count - h0, 6);
        check("s3_results", got_q.size(), 6);
        if (got_q.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                e = mul(t6a[k], t6b[k]);
                check($sformatf("s3_r%0d", k), got_q[k], e);
            end
        end
        check("s3_in_ready_back", IN_READY, 1);

        // Full FIFO: forced return coinciding with a pop. Nothing is outstanding,
        // so the forced return also counts as a protocol error and sets OVERFLOW.
        OUT_READY = 1'b0;
        issue_n(4, 8);
        cyc(15);
        check("s4_level_full", LEVEL, 4);
        inj_val = 16'h1234; inj_req = 1'b1;
        cyc(1);
        OUT_READY = 1'b1;
        cyc(1);
        OUT_READY = 1'b0;
        check("s4_level_kept", LEVEL, 4);
        check("s4_overflow", OVERFLOW, 1);
        got_q.delete(); OUT_READY = 1'b1;
        cyc(10);
        check("s4_results", got_q.size(), 4);
        if (got_q.size() == 4) check("s4_tail", got_q[3], 16'h1234);

        RESET = 1'b1; cyc(2); RESET = 1'b0; cyc(1);
        check("s5_overflow_cleared", OVERFLOW, 0);

        // Overflow: forced return into a full FIFO with the sink blocked.
        OUT_READY = 1'b0;
        issue_n(4, 8);
        cyc(15);
        inj_val = 16'h5A5A; inj_req = 1'b1;
        cyc(3);
        check("s5_level", LEVEL, 4);
        check("s5_overflow", OVERFLOW, 1);
        cyc(5);
        check("s5_overflow_sticky", OVERFLOW, 1);
        got_q.delete(); OUT_READY = 1'b1;
        cyc(10);
        check("s5_results", got_q.size(), 4);

        // Reset two cycles after START.
        RESET = 1'b1; cyc(2); RESET = 1'b0; cyc(1);
        OUT_READY = 1'b1; A_IN = 8'sd9; B_IN = 8'sd9; IN_VALID = 1'b1;
        cyc(1);
        IN_VALID = 1'b0;
        check("s6_start", START, 1);
        cyc(2);
        RESET = 1'b1;
        #1;
        check("s6_level", LEVEL, 0);
        check("s6_out_valid", OUT_VALID, 0);
        check("s6_in_ready", IN_READY, 1);
        cyc(2);
        RESET = 1'b0;
        vc = valid_count;
        cyc(20);
        check("s6_no_result", valid_count - vc, 0);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            if (!IN_VALID || IN_READY) begin
                IN_VALID = ($urandom_range(0, 2) != 0);
                A_IN = 8'($urandom);
                B_IN = 8'($urandom);
            end
            OUT_READY = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        cyc(40);
        check("end_level", LEVEL, 0);
        check("end_in_ready", IN_READY, 1);
        check("end_overflow", OVERFLOW, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
